ece423_qsys_cpu_debug_ocimem_ctrl: RTL

//  System-clock stage that sits directly downstream of the debug-slave sysclk decoder.
//  It turns one-cycle take_action/no_action strobes plus the 38-bit jdo word into

---
 rtl/ece423_qsys_cpu_debug_ocimem_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ece423_qsys_cpu_debug_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// ece423_qsys_cpu_debug_ocimem_ctrl
//
// System-clock stage behind the debug-slave sysclk decoder. It converts the
// one-cycle take_action/no_action strobes and the 38-bit jdo word into single
// read or write accesses to the on-chip debug RAM. Read data is returned in
// MonDReg. monitor_ready and monitor_error are captured by the JTAG TCK side.
//
// Parameters
//   RAM_AW   word-address width of the debug RAM (2**RAM_AW 32-bit words)
//   TIMEOUT  cycles mem_req may wait for mem_ack before the access is aborted
//            (1..255)
//
// Ports
//   clk, reset               system clock, asynchronous active-high reset
//   jdo                      JTAG data word, stable during the strobe cycle
//   take_action_ocimem_a     load MonAReg from jdo, read there if jdo[34]=1
//   take_action_ocimem_b     write jdo[34:3] at MonAReg
//   take_no_action_ocimem_a  read at MonAReg
//   mem_req/we/addr/wdata    RAM request, held stable until mem_ack
//   mem_ack/mem_rdata        RAM completion and read data
//   MonAReg                  current address, increments after each access
//   MonDReg                  last read data or last write data
//   monitor_ready            idle and last command finished
//   monitor_error            last command timed out
//   overrun                  sticky: a strobe arrived while busy and was lost
// ---------------------------------------------------------------------------
module ece423_qsys_cpu_debug_ocimem_ctrl #(
    parameter int RAM_AW  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic              mem_req,
    output logic              mem_we,
    output logic [RAM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [RAM_AW-1:0] MonAReg,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              overrun
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // The wait counter is compared against this value; hitting it with no
    // ack means the access has been outstanding for TIMEOUT cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state_reg;
    logic [7:0]        wait_cnt_reg;
    logic [RAM_AW-1:0] new_addr;
    logic [31:0]       jdo_data;
    logic              any_strobe;

    // Bits of jdo that carry neither address nor data.
    logic              jdo_unused;

    assign new_addr   = jdo[17 +: RAM_AW];
    assign jdo_data   = jdo[34:3];
    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b |
                        take_no_action_ocimem_a;
    assign jdo_unused = ^{jdo[37:35], jdo[2:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= 8'd0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= 32'd0;
            MonAReg       <= '0;
            MonDReg       <= 32'd0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // With nothing pending, ready is (re)asserted. This also
                    // covers the address-only ocimem_a, which drops ready for
                    // exactly one cycle.
                    monitor_ready <= 1'b1;
                    if (take_action_ocimem_b) begin
                        mem_wdata     <= jdo_data;
                        MonDReg       <= jdo_data;
                        mem_we        <= 1'b1;
                        mem_addr      <= MonAReg;
                        mem_req       <= 1'b1;
                        wait_cnt_reg  <= 8'd0;
                        state_reg     <= ACCESS;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                        overrun       <= 1'b0;
                    end else if (take_action_ocimem_a) begin
                        MonAReg       <= new_addr;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                        overrun       <= 1'b0;
                        if (jdo[34]) begin
                            mem_we       <= 1'b0;
                            mem_addr     <= new_addr;
                            mem_req      <= 1'b1;
                            wait_cnt_reg <= 8'd0;
                            state_reg    <= ACCESS;
                        end
                    end else if (take_no_action_ocimem_a) begin
                        mem_we        <= 1'b0;
                        mem_addr      <= MonAReg;
                        mem_req       <= 1'b1;
                        wait_cnt_reg  <= 8'd0;
                        state_reg     <= ACCESS;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                        overrun       <= 1'b0;
                    end
                end

                ACCESS: begin
                    // Strobes cannot be queued; remember that one was lost.
                    if (any_strobe) begin
                        overrun <= 1'b1;
                    end
                    // An ack on the last allowed cycle still wins over the
                    // timeout, so it is tested first.
                    if (mem_ack) begin
                        mem_req       <= 1'b0;
                        monitor_ready <= 1'b1;
                        MonAReg       <= MonAReg + RAM_AW'(1);
                        if (!mem_we) begin
                            MonDReg <= mem_rdata;
                        end
                        state_reg     <= IDLE;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        mem_req       <= 1'b0;
                        monitor_error <= 1'b1;
                        monitor_ready <= 1'b1;
                        state_reg     <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
